// File: rtl/mbist_pkg.sv
// Shared definitions for the March C- MBIST controller: state encoding and
// the per-element operation table.
package mbist_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_M0   = 3'd1;
    localparam state_t ST_M1   = 3'd2;
    localparam state_t ST_M2   = 3'd3;
    localparam state_t ST_M3   = 3'd4;
    localparam state_t ST_M4   = 3'd5;
    localparam state_t ST_M5   = 3'd6;
    localparam state_t ST_DONE = 3'd7;

    typedef struct packed {
        logic dir_up;
        logic rd_val;
        logic wr_val;
        logic has_rd;
        logic has_wr;
    } elem_t;

    // Fields in order: dir_up, rd_val, wr_val, has_rd, has_wr.
    function automatic elem_t elem_cfg(input state_t st);
        elem_t e;
        e = '0;
        case (st)
            ST_M0:   e = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
            ST_M1:   e = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
            ST_M2:   e = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
            ST_M3:   e = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
            ST_M4:   e = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
            ST_M5:   e = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic logic is_march(input state_t st);
        return (st != ST_IDLE) && (st != ST_DONE);
    endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// Up/down address counter for the march elements, with explicit load-0 and
// load-max so element boundaries never rely on wrap-around.
module mbist_addr_gen #(
    parameter int ADDR = 6
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load0_i,
    input  logic            loadmax_i,
    input  logic            en_i,
    input  logic            up_i,
    output logic [ADDR-1:0] addr_o,
    output logic            last_o
);

    logic [ADDR-1:0] addr_q;
    logic [ADDR-1:0] addr_d;

    always_comb begin
        addr_d = addr_q;
        if (load0_i) begin
            addr_d = '0;
        end else if (loadmax_i) begin
            addr_d = '1;
        end else if (en_i) begin
            addr_d = up_i ? (addr_q + ADDR'(1)) : (addr_q - ADDR'(1));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = up_i ? (addr_q == '1) : (addr_q == '0);

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- BIST controller for a 1-bit single-port RAM; one memory op per
// clock, Moore-decoded memory controls, sticky fault and done flags.
//
// state | meaning
// IDLE  | functional mode, memory controls inactive
// M0    | up   (w0)
// M1    | up   (r0, w1)
// M2    | up   (r1, w0)
// M3    | down (r0, w1)
// M4    | down (r1, w0)
// M5    | up   (r0)
// DONE  | test finished, hold until mode drops
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int ADDR = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mode,
    input  logic            mem_d_out,
    output logic [ADDR-1:0] mem_addr,
    output logic            mem_pattern,
    output logic            cs_bist,
    output logic            we_bist,
    output logic            oe_bist,
    output logic            fault_flag,
    output logic            bist_done
);

    state_t state_q, state_d;
    logic   phase_q, phase_d;
    logic   fault_q, fault_d;
    logic   done_q,  done_d;

    elem_t  cfg;
    elem_t  nxt_cfg;
    state_t st_next;
    logic   active;
    logic   is_rd;
    logic   is_wr;
    logic   op_last;
    logic   load0;
    logic   loadmax;
    logic   addr_en;
    logic   addr_last;
    logic [ADDR-1:0] addr;

    assign cfg     = elem_cfg(state_q);
    assign st_next = state_q + 3'd1;
    assign nxt_cfg = elem_cfg(st_next);
    assign active  = is_march(state_q);

    // phase_q=0 is the read half of a two-op element; single-op elements stay at 0.
    assign is_rd   = cfg.has_rd & ~phase_q;
    assign is_wr   = cfg.has_wr & (~cfg.has_rd | phase_q);
    assign op_last = ~(cfg.has_rd & cfg.has_wr) | phase_q;

    mbist_addr_gen #(
        .ADDR(ADDR)
    ) u_addr_gen (
        .clk_i     (clk),
        .rst_i     (rst),
        .load0_i   (load0),
        .loadmax_i (loadmax),
        .en_i      (addr_en),
        .up_i      (cfg.dir_up),
        .addr_o    (addr),
        .last_o    (addr_last)
    );

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        fault_d = fault_q;
        done_d  = done_q;
        load0   = 1'b0;
        loadmax = 1'b0;
        addr_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mode) begin
                    state_d = ST_M0;
                    phase_d = 1'b0;
                    load0   = 1'b1;
                    fault_d = 1'b0;
                    done_d  = 1'b0;
                end
            end
            ST_DONE: begin
                if (!mode) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                if (!mode) begin
                    state_d = ST_IDLE;
                    phase_d = 1'b0;
                    done_d  = 1'b0;
                end else begin
                    if (is_rd && (mem_d_out != cfg.rd_val)) begin
                        fault_d = 1'b1;
                    end
                    if (op_last) begin
                        phase_d = 1'b0;
                        if (addr_last) begin
                            state_d = st_next;
                            if (st_next == ST_DONE) begin
                                done_d = 1'b1;
                            end else if (nxt_cfg.dir_up) begin
                                load0 = 1'b1;
                            end else begin
                                loadmax = 1'b1;
                            end
                        end else begin
                            addr_en = 1'b1;
                        end
                    end else begin
                        phase_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            phase_q <= 1'b0;
            fault_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            fault_q <= fault_d;
            done_q  <= done_d;
        end
    end

    assign cs_bist     = active;
    assign oe_bist     = active & is_rd;
    assign we_bist     = active & is_wr;
    assign mem_addr    = active ? addr : '0;
    assign mem_pattern = active & is_wr & cfg.wr_val;
    assign fault_flag  = fault_q;
    assign bist_done   = done_q;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: behavioural 64x1 RAM with optional stuck-at
// cell, table of expected memory ops for a full run, plus corner sequences.
module tb_mbist_march_ctrl;

    localparam int ADDR = 6;
    localparam int N    = 1 << ADDR;
    localparam int TLEN = 10 * N;

    logic            clk;
    logic            rst;
    logic            mode;
    logic            mem_d_out;
    logic [ADDR-1:0] mem_addr;
    logic            mem_pattern;
    logic            cs_bist;
    logic            we_bist;
    logic            oe_bist;
    logic            fault_flag;
    logic            bist_done;

    mbist_march_ctrl #(.ADDR(ADDR)) dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .mem_d_out   (mem_d_out),
        .mem_addr    (mem_addr),
        .mem_pattern (mem_pattern),
        .cs_bist     (cs_bist),
        .we_bist     (we_bist),
        .oe_bist     (oe_bist),
        .fault_flag  (fault_flag),
        .bist_done   (bist_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model; flt_kind 1 = stuck-at-0, 2 = stuck-at-1 at flt_addr.
    logic       mem [0:N-1];
    int         flt_kind;
    logic [5:0] flt_addr;

    always @(posedge clk) begin
        if (cs_bist && we_bist) mem[mem_addr] <= mem_pattern;
    end

    always_comb begin
        mem_d_out = 1'b0;
        if (cs_bist && oe_bist) begin
            mem_d_out = mem[mem_addr];
            if (flt_kind == 1 && mem_addr == flt_addr) mem_d_out = 1'b0;
            if (flt_kind == 2 && mem_addr == flt_addr) mem_d_out = 1'b1;
        end
    end

    typedef struct {
        int         op;
        logic [5:0] addr;
        logic       cs;
        logic       we;
        logic       oe;
        logic       pat;
    } vec_t;

    localparam int NT = 19;
    vec_t tbl [NT];

    int n_vec;
    int n_err;
    int cur_op;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [9:0] outs();
        return {cs_bist, we_bist, oe_bist, mem_pattern, mem_addr};
    endfunction

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
        cur_op += n;
    endtask

    task automatic run_to(input int op);
        adv(op - cur_op);
    endtask

    // Leaves the bench at the negedge inside op 0 (just after start edge k).
    task automatic start_test();
        mode = 1'b0;
        @(negedge clk);
        mode = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cur_op = 0;
    endtask

    task automatic run_done_check(input string nm);
        run_to(TLEN - 1);
        chk({nm, "_done_pre"}, bist_done, 1'b0);
        adv(1);
        chk({nm, "_done"}, bist_done, 1'b1);
    endtask

    initial begin
        logic saw_fault;
        n_vec = 0;
        n_err = 0;
        cur_op = 0;
        flt_kind = 0;
        flt_addr = '0;
        rst = 1'b1;
        mode = 1'b0;

        //           op   addr cs we oe pat
        tbl[0]  = '{0,   6'd0,  1, 1, 0, 0};
        tbl[1]  = '{1,   6'd1,  1, 1, 0, 0};
        tbl[2]  = '{63,  6'd63, 1, 1, 0, 0};
        tbl[3]  = '{64,  6'd0,  1, 0, 1, 0};
        tbl[4]  = '{65,  6'd0,  1, 1, 0, 1};
        tbl[5]  = '{66,  6'd1,  1, 0, 1, 0};
        tbl[6]  = '{191, 6'd63, 1, 1, 0, 1};
        tbl[7]  = '{192, 6'd0,  1, 0, 1, 0};
        tbl[8]  = '{193, 6'd0,  1, 1, 0, 0};
        tbl[9]  = '{320, 6'd63, 1, 0, 1, 0};
        tbl[10] = '{321, 6'd63, 1, 1, 0, 1};
        tbl[11] = '{322, 6'd62, 1, 0, 1, 0};
        tbl[12] = '{447, 6'd0,  1, 1, 0, 1};
        tbl[13] = '{448, 6'd63, 1, 0, 1, 0};
        tbl[14] = '{449, 6'd63, 1, 1, 0, 0};
        tbl[15] = '{575, 6'd0,  1, 1, 0, 0};
        tbl[16] = '{576, 6'd0,  1, 0, 1, 0};
        tbl[17] = '{577, 6'd1,  1, 0, 1, 0};
        tbl[18] = '{639, 6'd63, 1, 0, 1, 0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", outs(), 10'd0);
        chk("reset_flags", {fault_flag, bist_done}, 2'b00);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outs", outs(), 10'd0);

        // Fault-free full run against the op table.
        start_test();
        saw_fault = 1'b0;
        for (int op = 0; op < TLEN; op++) begin
            for (int t = 0; t < NT; t++) begin
                if (tbl[t].op == op) begin
                    chk($sformatf("op%0d", op), outs(),
                        {tbl[t].cs, tbl[t].we, tbl[t].oe, tbl[t].pat, tbl[t].addr});
                end
            end
            if (op == 1) chk("mem0_written", mem[0], 1'b0);
            if (fault_flag) saw_fault = 1'b1;
            if (op == TLEN - 1) chk("ff_done_pre", bist_done, 1'b0);
            adv(1);
        end
        chk("ff_done", bist_done, 1'b1);
        chk("ff_fault_end", fault_flag, 1'b0);
        chk("ff_fault_seen", saw_fault, 1'b0);
        chk("ff_done_outs", outs(), 10'd0);

        // Cell 0 stuck-at-1: first M1 read of address 0 (op 64).
        flt_kind = 2;
        flt_addr = 6'd0;
        start_test();
        run_to(64);
        chk("sa1_pre", fault_flag, 1'b0);
        adv(1);
        chk("sa1_set", fault_flag, 1'b1);
        run_done_check("sa1");
        chk("sa1_fault_done", fault_flag, 1'b1);

        // DONE holds with mode=1, then restart clears flags.
        for (int i = 0; i < 5; i++) begin
            adv(1);
            chk("hold_outs", outs(), 10'd0);
            chk("hold_done", {bist_done, fault_flag}, 2'b11);
        end
        mode = 1'b0;
        adv(1);
        chk("idle_retain", {bist_done, fault_flag}, 2'b11);

        // Cell 5 stuck-at-0: caught at M2 r1 of address 5 (op 202).
        flt_kind = 1;
        flt_addr = 6'd5;
        start_test();
        chk("restart_flags", {bist_done, fault_flag}, 2'b00);
        chk("restart_op0", outs(), {4'b1100, 6'd0});
        run_to(202);
        chk("sa0_pre", fault_flag, 1'b0);
        adv(1);
        chk("sa0_set", fault_flag, 1'b1);
        run_done_check("sa0");
        chk("sa0_fault_done", fault_flag, 1'b1);

        // Mode dropped at op 300 while a fault is latched.
        start_test();
        run_to(300);
        chk("drop_fault_pre", fault_flag, 1'b1);
        mode = 1'b0;
        adv(1);
        chk("drop_outs", outs(), 10'd0);
        chk("drop_flags", {bist_done, fault_flag}, 2'b01);
        adv(1);
        chk("drop_idle", outs(), 10'd0);
        flt_kind = 0;
        start_test();
        chk("drop_restart_op0", outs(), {4'b1100, 6'd0});
        chk("drop_restart_flags", {bist_done, fault_flag}, 2'b00);
        run_to(1);
        chk("drop_restart_op1", outs(), {4'b1100, 6'd1});

        // Reset at op 100 after a fault is latched.
        flt_kind = 2;
        flt_addr = 6'd0;
        start_test();
        run_to(100);
        chk("rst_fault_pre", fault_flag, 1'b1);
        rst = 1'b1;
        mode = 1'b0;
        adv(1);
        chk("rst_outs", outs(), 10'd0);
        chk("rst_flags", {bist_done, fault_flag}, 2'b00);
        rst = 1'b0;
        adv(1);
        chk("rst_idle", outs(), 10'd0);
        flt_kind = 0;
        start_test();
        chk("rst_restart_op0", outs(), {4'b1100, 6'd0});
        run_done_check("rst");
        chk("rst_fault_end", fault_flag, 1'b0);

        mode = 1'b0;
        adv(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
